uart_tx_fifo_param: RTL

//  Parametrised UART transmitter with input FIFO; generalises the 8N1 serial framing driven on RX/TX in the TP2 UART-ALU design.

---
 rtl/uart_tx_fifo_param.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_tx_fifo_param                                             |
// | Purpose : Parametrised UART transmitter fed by a small circular FIFO.    |
// |           Frames are START, DATA_BITS data bits (LSB first), optional    |
// |           parity bit, then STOP_BITS stop bits; each bit is held for     |
// |           CLKS_PER_BIT clock cycles. Back-to-back frames carry no idle   |
// |           gap while the FIFO has words.                                  |
// | Option  : define UART_TX_PARITY_EN to insert a parity bit after the data |
// |           bits (even parity, or odd when PARITY_ODD=1).                  |
// | Ports   : clk        - system clock, rising edge                         |
// |           reset      - synchronous, active-high                          |
// |           tx_data    - word to queue                                     |
// |           tx_wr      - write strobe, one cycle per word                  |
// |           tx_full    - FIFO holds 2**FIFO_AW words                       |
// |           tx_empty   - FIFO holds no words                               |
// |           fifo_count - words queued (frame in flight not included)       |
// |           tx_busy    - a frame is in progress                            |
// |           tx_ovr     - sticky: write attempted while full                |
// |           tx         - registered serial line, idle high                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module uart_tx_fifo_param #(
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 2604,
   parameter int FIFO_AW      = 2,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_wr,
   output logic                 tx_full,
   output logic                 tx_empty,
   output logic [FIFO_AW:0]     fifo_count,
   output logic                 tx_busy,
   output logic                 tx_ovr,
   output logic                 tx
);

   localparam int DEPTH  = 2**FIFO_AW;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [FIFO_AW:0]   C_FULL_CNT  = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   C_CNT_ONE   = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] C_PTR_ONE   = FIFO_AW'(1);
   localparam logic [BAUD_W-1:0]  C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT-1);
   localparam logic [BAUD_W-1:0]  C_BAUD_ONE  = BAUD_W'(1);
   localparam logic [BIT_W-1:0]   C_DATA_LAST = BIT_W'(DATA_BITS-1);
   localparam logic [BIT_W-1:0]   C_STOP_LAST = BIT_W'(STOP_BITS-1);
   localparam logic [BIT_W-1:0]   C_BIT_ONE   = BIT_W'(1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd4
   } state_t;
`endif

   // ---------------------------------------------------------------- FIFO
   logic [DATA_BITS-1:0] r_mem [DEPTH];
   logic [FIFO_AW-1:0]   r_wr_ptr;
   logic [FIFO_AW-1:0]   r_rd_ptr;
   logic [FIFO_AW:0]     r_count;
   logic [FIFO_AW:0]     w_count_next;
   logic                 w_push;
   logic                 w_pop;

   // Acceptance looks only at the registered full flag, so a write that
   // coincides with a pop from a full FIFO is still dropped.
   assign w_push     = tx_wr && !tx_full;
   assign fifo_count = r_count;

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + C_CNT_ONE;
         2'b01:   w_count_next = r_count - C_CNT_ONE;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         tx_full  <= 1'b0;
         tx_empty <= 1'b1;
         tx_ovr   <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         r_count  <= w_count_next;
         tx_full  <= (w_count_next == C_FULL_CNT);
         tx_empty <= (w_count_next == '0);
         if (tx_wr && tx_full) tx_ovr <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= tx_data;
   end

   // -------------------------------------------------------- frame engine
   state_t               r_state;
   state_t               w_state_next;
   logic [BAUD_W-1:0]    r_baud;
   logic [BIT_W-1:0]     r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 w_bit_end;
   logic                 w_tx_bit;

   assign w_bit_end = (r_baud == C_BAUD_LAST);
   assign tx_busy   = (r_state != S_IDLE);

`ifdef UART_TX_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk) begin
      if (reset)      r_parity <= 1'b0;
      else if (w_pop) r_parity <= (^r_mem[r_rd_ptr]) ^ (PARITY_ODD != 0);
   end
`else
   logic w_unused_parity_odd;
   assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_tx_bit     = 1'b1;
      case (r_state)
         S_IDLE: begin
            if (!tx_empty) begin
               w_pop        = 1'b1;
               w_state_next = S_START;
            end
         end
         S_START: begin
            w_tx_bit = 1'b0;
            if (w_bit_end) w_state_next = S_DATA;
         end
         S_DATA: begin
            w_tx_bit = r_shift[0];
            if (w_bit_end && (r_bit == C_DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
               w_state_next = S_PARITY;
`else
               w_state_next = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            w_tx_bit = r_parity;
            if (w_bit_end) w_state_next = S_STOP;
         end
`endif
         S_STOP: begin
            // Last stop-bit cycle chains straight into the next START.
            if (w_bit_end && (r_bit == C_STOP_LAST)) begin
               if (!tx_empty) begin
                  w_pop        = 1'b1;
                  w_state_next = S_START;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // The line is a registered copy of the current bit, so it trails the
   // state register by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         tx      <= 1'b1;
      end else begin
         tx <= w_tx_bit;

         if ((r_state == S_IDLE) || w_bit_end) r_baud <= '0;
         else                                  r_baud <= r_baud + C_BAUD_ONE;

         // Bit counter indexes data bits in DATA and stop bits in STOP.
         if (w_state_next != r_state) r_bit <= '0;
         else if (w_bit_end)          r_bit <= r_bit + C_BIT_ONE;

         if (w_pop)                                  r_shift <= r_mem[r_rd_ptr];
         else if ((r_state == S_DATA) && w_bit_end)  r_shift <= r_shift >> 1;
      end
   end

endmodule
`default_nettype wire
